// File: rtl/pbit_anneal_scheduler.sv
// Annealing sequencer for a graph-coloured p-bit array: colour update pulses, settle waits, sample strobes, beta ramp.
// Latency: first colour_en one cycle after start is sampled; every output is registered.
// No backpressure: the run is free-running once started and stops only on completion, abort or reset.
module pbit_anneal_scheduler #(
  parameter int N_COLORS        = 2,
  parameter int BETA_W          = 16,
  parameter int BETA_START      = 16,
  parameter int BETA_STEP       = 8,
  parameter int BETA_MAX        = 32,
  parameter int SETTLE_CYCLES   = 4,
  parameter int SWEEPS_PER_STEP = 3,
  parameter int NUM_STEPS       = 4
) (
  input  logic                               clk_mac,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               abort,
  output logic signed [BETA_W-1:0]           o_beta,
  output logic [N_COLORS-1:0]                colour_en,
  output logic                               busy,
  output logic                               sample_valid,
  output logic [$clog2(NUM_STEPS+1)-1:0]     step_idx,
  output logic                               done
);

  localparam int SIW  = $clog2(NUM_STEPS + 1);
  localparam int CW   = (N_COLORS > 1)        ? $clog2(N_COLORS)        : 1;
  localparam int SWW  = (SWEEPS_PER_STEP > 1) ? $clog2(SWEEPS_PER_STEP) : 1;
  localparam int SETW = (SETTLE_CYCLES > 1)   ? $clog2(SETTLE_CYCLES)   : 1;

  localparam logic [CW-1:0]   COL_LAST  = CW'(N_COLORS - 1);
  localparam logic [SWW-1:0]  SW_LAST   = SWW'(SWEEPS_PER_STEP - 1);
  localparam logic [SIW-1:0]  STEP_LAST = SIW'(NUM_STEPS - 1);
  localparam logic [SETW-1:0] SET_LOAD  = SETW'(SETTLE_CYCLES - 1);

  // Beta arithmetic is done one bit wider than the bus so the sum never wraps.
  localparam logic signed [BETA_W-1:0] START_V = BETA_W'(BETA_START);
  localparam logic signed [BETA_W:0]   STEP_X  = (BETA_W + 1)'(BETA_STEP);
  localparam logic signed [BETA_W:0]   MAX_X   = (BETA_W + 1)'(BETA_MAX);
  localparam logic signed [BETA_W:0]   POS_LIM = {2'b00, {(BETA_W - 1){1'b1}}};
  localparam logic signed [BETA_W:0]   NEG_LIM = {2'b11, {(BETA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPDATE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   colour, colour_nxt;
  logic [SWW-1:0]  sweep, sweep_nxt;
  logic [SIW-1:0]  step, step_nxt;
  logic [SETW-1:0] settle, settle_nxt;

  logic signed [BETA_W:0]   beta_sum;
  logic signed [BETA_W:0]   beta_clamp;
  logic signed [BETA_W-1:0] beta_sat;

  logic signed [BETA_W-1:0] beta_nxt;
  logic [N_COLORS-1:0]      colour_en_nxt;
  logic                     busy_nxt;
  logic                     sample_nxt;
  logic [SIW-1:0]           step_idx_nxt;
  logic                     done_nxt;

  // State and slot counters register
  always_ff @(posedge clk_mac or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      colour <= '0;
      sweep  <= '0;
      step   <= '0;
      settle <= '0;
    end else begin
      state  <= state_nxt;
      colour <= colour_nxt;
      sweep  <= sweep_nxt;
      step   <= step_nxt;
      settle <= settle_nxt;
    end
  end

  // Next-state and counter sequencing; abort overrides everything outside IDLE
  always_comb begin
    state_nxt  = state;
    colour_nxt = colour;
    sweep_nxt  = sweep;
    step_nxt   = step;
    settle_nxt = settle;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt  = S_UPDATE;
          colour_nxt = '0;
          sweep_nxt  = '0;
          step_nxt   = '0;
        end
      end
      S_UPDATE: begin
        state_nxt  = S_SETTLE;
        settle_nxt = SET_LOAD;
      end
      S_SETTLE: begin
        if (settle != '0) begin
          settle_nxt = settle - 1'b1;
        end else if (colour != COL_LAST) begin
          colour_nxt = colour + 1'b1;
          state_nxt  = S_UPDATE;
        end else begin
          colour_nxt = '0;
          sweep_nxt  = sweep + 1'b1;
          state_nxt  = (sweep == SW_LAST) ? S_SAMPLE : S_UPDATE;
        end
      end
      S_SAMPLE: begin
        if (step == STEP_LAST) begin
          state_nxt = S_DONE;
        end else begin
          step_nxt  = step + 1'b1;
          sweep_nxt = '0;
          state_nxt = S_UPDATE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // Saturating beta increment: clamp at BETA_MAX in the ramp direction, then at the bus range
  always_comb begin
    beta_sum   = $signed({o_beta[BETA_W-1], o_beta}) + STEP_X;
    beta_clamp = beta_sum;
    if (BETA_STEP >= 0) begin
      if (beta_sum > MAX_X) begin
        beta_clamp = MAX_X;
      end else if (beta_sum > POS_LIM) begin
        beta_clamp = POS_LIM;
      end
    end else begin
      if (beta_sum < MAX_X) begin
        beta_clamp = MAX_X;
      end else if (beta_sum < NEG_LIM) begin
        beta_clamp = NEG_LIM;
      end
    end
    beta_sat = beta_clamp[BETA_W-1:0];
  end

  // Output values for the next cycle, decoded from the upcoming state so outputs stay registered
  always_comb begin
    beta_nxt      = o_beta;
    colour_en_nxt = '0;
    busy_nxt      = (state_nxt != S_IDLE);
    sample_nxt    = (state_nxt == S_SAMPLE);
    done_nxt      = (state_nxt == S_DONE);
    step_idx_nxt  = step_idx;
    if (state_nxt == S_UPDATE) begin
      colour_en_nxt = N_COLORS'(1) << colour_nxt;
    end
    if ((state == S_IDLE) && (state_nxt == S_UPDATE)) begin
      beta_nxt     = START_V;
      step_idx_nxt = '0;
    end
    if (state_nxt == S_SAMPLE) begin
      step_idx_nxt = step_nxt;
    end
    if ((state == S_SAMPLE) && (state_nxt == S_UPDATE)) begin
      beta_nxt = beta_sat;
    end
  end

  // Output register
  always_ff @(posedge clk_mac or negedge reset_n) begin
    if (!reset_n) begin
      o_beta       <= '0;
      colour_en    <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      step_idx     <= '0;
      done         <= 1'b0;
    end else begin
      o_beta       <= beta_nxt;
      colour_en    <= colour_en_nxt;
      busy         <= busy_nxt;
      sample_valid <= sample_nxt;
      step_idx     <= step_idx_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pbit_anneal_scheduler.sv
// Bench for pbit_anneal_scheduler: default-ramp instance plus a falling-ramp instance.
// Expected colour pulses, samples and done pulses are queued with their cycle numbers.
// Monitors pop and compare whenever a DUT raises colour_en, sample_valid or done.
module tb_pbit_anneal_scheduler;

  logic              clk_mac;
  logic              reset_n;
  logic              start, abort;
  logic              start2, abort2;
  logic signed [15:0] o_beta, o_beta2;
  logic [1:0]        colour_en, colour_en2;
  logic              busy, busy2;
  logic              sample_valid, sample_valid2;
  logic [2:0]        step_idx, step_idx2;
  logic              done, done2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cy;
    int v0;
    int v1;
  } ev_t;

  ev_t q_col[$];
  ev_t q_smp[$];
  ev_t q_done[$];
  ev_t q2_smp[$];
  ev_t q2_done[$];

  int beta_def[4] = '{16, 24, 32, 32};
  int beta_neg[4] = '{0, -8, -12, -12};

  pbit_anneal_scheduler dut (
    .clk_mac      (clk_mac),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .o_beta       (o_beta),
    .colour_en    (colour_en),
    .busy         (busy),
    .sample_valid (sample_valid),
    .step_idx     (step_idx),
    .done         (done)
  );

  pbit_anneal_scheduler #(
    .BETA_START (0),
    .BETA_STEP  (-8),
    .BETA_MAX   (-12)
  ) dut_neg (
    .clk_mac      (clk_mac),
    .reset_n      (reset_n),
    .start        (start2),
    .abort        (abort2),
    .o_beta       (o_beta2),
    .colour_en    (colour_en2),
    .busy         (busy2),
    .sample_valid (sample_valid2),
    .step_idx     (step_idx2),
    .done         (done2)
  );

  initial clk_mac = 1'b0;
  always #5 clk_mac = ~clk_mac;

  always @(posedge clk_mac) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Queue every event of a run starting with first UPDATE at cycle f, up to cycle lim.
  // Slot 5 cycles, sweep 10, beta step 31 (30 + SAMPLE), done at f+124.
  task automatic push_run(input int f, input int lim, input bit second);
    int cy;
    for (int st = 0; st < 4; st++) begin
      for (int sw = 0; sw < 3; sw++) begin
        for (int c = 0; c < 2; c++) begin
          cy = f + st * 31 + sw * 10 + c * 5;
          if (!second && cy <= lim) q_col.push_back(ev_t'{cy, 1 << c, 0});
        end
      end
      cy = f + st * 31 + 30;
      if (cy <= lim) begin
        if (second) q2_smp.push_back(ev_t'{cy, st, beta_neg[st]});
        else        q_smp.push_back(ev_t'{cy, st, beta_def[st]});
      end
    end
    cy = f + 124;
    if (cy <= lim) begin
      if (second) q2_done.push_back(ev_t'{cy, 0, 0});
      else        q_done.push_back(ev_t'{cy, 0, 0});
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_mac);
      #1;
    end
  endtask

  task automatic pulse_start(input bit both, output int f);
    @(posedge clk_mac);
    #1;
    start = 1'b1;
    if (both) start2 = 1'b1;
    @(posedge clk_mac);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    f = cyc;
  endtask

  // Scoreboard monitor for the default instance
  always @(negedge clk_mac) begin
    if (reset_n) begin
      if (colour_en != 2'b00) begin
        if (q_col.size() == 0) unexpected("colour_en");
        else begin
          ev_t e;
          e = q_col.pop_front();
          chk("colour_cycle", cyc, e.cy);
          chk("colour_en", colour_en, e.v0);
        end
      end
      if (sample_valid) begin
        if (q_smp.size() == 0) unexpected("sample_valid");
        else begin
          ev_t e;
          e = q_smp.pop_front();
          chk("sample_cycle", cyc, e.cy);
          chk("sample_step_idx", step_idx, e.v0);
          chk("sample_beta", o_beta, e.v1);
        end
      end
      if (done) begin
        if (q_done.size() == 0) unexpected("done");
        else begin
          ev_t e;
          e = q_done.pop_front();
          chk("done_cycle", cyc, e.cy);
        end
      end
    end
  end

  // Scoreboard monitor for the falling-ramp instance
  always @(negedge clk_mac) begin
    if (reset_n) begin
      if (sample_valid2) begin
        if (q2_smp.size() == 0) unexpected("neg_sample_valid");
        else begin
          ev_t e;
          e = q2_smp.pop_front();
          chk("neg_sample_cycle", cyc, e.cy);
          chk("neg_sample_step_idx", step_idx2, e.v0);
          chk("neg_sample_beta", o_beta2, e.v1);
        end
      end
      if (done2) begin
        if (q2_done.size() == 0) unexpected("neg_done");
        else begin
          ev_t e;
          e = q2_done.pop_front();
          chk("neg_done_cycle", cyc, e.cy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    start2  = 1'b0;
    abort2  = 1'b0;
    #1;
    chk("rst_o_beta", o_beta, 0);
    chk("rst_colour_en", colour_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk_mac);
    #2;
    reset_n = 1'b1;
    wait_until(cyc + 2);
    chk("idle_busy", busy, 0);

    // Full run on both instances, with stray start pulses mid-run and in the DONE cycle
    pulse_start(1'b1, f);
    push_run(f, f + 200, 1'b0);
    push_run(f, f + 200, 1'b1);
    chk("run1_busy", busy, 1);
    chk("run1_beta_start", o_beta, 16);
    chk("neg_beta_start", o_beta2, 0);
    wait_until(f + 40);
    start = 1'b1;
    wait_until(f + 41);
    start = 1'b0;
    wait_until(f + 124);
    chk("done_cycle_busy", busy, 1);
    start = 1'b1;
    wait_until(f + 125);
    start = 1'b0;
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);
    chk("after_done_beta", o_beta, 32);
    chk("neg_after_done_busy", busy2, 0);
    wait_until(f + 140);
    chk("no_second_run_busy", busy, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    wait_until(cyc + 1);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    wait_until(cyc + 3);
    chk("start_abort_busy_later", busy, 0);
    chk("start_abort_colour", colour_en, 0);

    // Abort in SETTLE of sweep 1, step 2 (first UPDATE of that sweep at f+72)
    pulse_start(1'b0, f);
    push_run(f, f + 74, 1'b0);
    wait_until(f + 74);
    abort = 1'b1;
    wait_until(f + 75);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_colour_en", colour_en, 0);
    chk("abort_sample_valid", sample_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_beta_hold", o_beta, 32);
    chk("abort_step_idx_hold", step_idx, 1);
    wait_until(f + 90);
    chk("abort_stays_idle", busy, 0);

    // Restart after abort, then reset in the second colour's UPDATE cycle
    pulse_start(1'b0, f);
    push_run(f, f + 4, 1'b0);
    chk("restart_beta", o_beta, 16);
    chk("restart_step_idx", step_idx, 0);
    chk("restart_busy", busy, 1);
    wait_until(f + 5);
    chk("pre_reset_colour_en", colour_en, 2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_o_beta", o_beta, 0);
    chk("async_rst_colour_en", colour_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sample_valid", sample_valid, 0);
    chk("async_rst_step_idx", step_idx, 0);
    chk("async_rst_done", done, 0);
    wait_until(cyc + 2);
    #2;
    reset_n = 1'b1;
    wait_until(cyc + 3);
    chk("post_reset_busy", busy, 0);

    chk("q_col_drained", q_col.size(), 0);
    chk("q_smp_drained", q_smp.size(), 0);
    chk("q_done_drained", q_done.size(), 0);
    chk("q2_smp_drained", q2_smp.size(), 0);
    chk("q2_done_drained", q2_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
